instr_issuer: RTL and testbench
===============================

INSTR_ISSUER -- requirements
Module: instr_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of instruction buffer entries (power of two).
REQ-002 The block SHALL have parameter GAP, default 6, meaning the clock cycles between successive newInstr pulses (minimum 2).
REQ-003 The block SHALL have the port Clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port Reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have the port loadEn  input  1  buffer write strobe.
REQ-006 The block SHALL have the port loadAddr  input  log2(DEPTH)  buffer write index.
REQ-007 The block SHALL have the port loadData  input  32  instruction word to store.
REQ-008 The block SHALL have the port start  input  1  one-cycle request to issue a program.
REQ-009 The block SHALL have the port count  input  log2(DEPTH)+1  number of instructions to issue, sampled with start.
REQ-010 The block SHALL have the port instrWord  output  32  instruction presented to the CPU.
REQ-011 The block SHALL have the port newInstr  output  1  one-cycle pulse marking instrWord as a new instruction.
REQ-012 The block SHALL have the port busy  output  1  high while a program is being issued.
REQ-013 The block SHALL have the port done  output  1  one-cycle pulse at program completion.
REQ-014 The block SHALL have the port pc  output  log2(DEPTH)  index of the entry most recently issued.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, with all outputs registered.
REQ-016 In IDLE, a loadEn pulse SHALL write loadData into buffer[loadAddr] at the clock edge.
REQ-017 A loadEn pulse SHALL be ignored in every state other than IDLE.
REQ-018 In IDLE, start with count==0 SHALL move the FSM to DONE and SHALL NOT pulse newInstr.
REQ-019 In IDLE, start with count>0 SHALL latch min(count,DEPTH), clear pc to 0 and move to ISSUE.
REQ-020 A start pulse received in any state other than IDLE SHALL be ignored.
REQ-021 The first newInstr pulse SHALL be high exactly 2 cycles after the edge that samples start.
REQ-022 In ISSUE, for exactly one cycle, instrWord SHALL be buffer[pc] and newInstr SHALL be 1; the FSM then moves to WAIT.
REQ-023 Rising edges of newInstr SHALL be exactly GAP cycles apart.
REQ-024 In WAIT, if instructions remain, the FSM SHALL increment pc (wrapping modulo DEPTH) and return to ISSUE.
REQ-025 In WAIT, if no instructions remain, the FSM SHALL move to DONE after GAP-1 cycles.
REQ-026 instrWord SHALL hold its last issued value until the next ISSUE, never changing while newInstr is low.
REQ-027 In DONE, done SHALL be 1 for one cycle and the FSM SHALL return to IDLE.
REQ-028 busy SHALL be 1 in ISSUE and WAIT and 0 in IDLE and DONE.
REQ-029 The last newInstr pulse SHALL be followed by done exactly GAP cycles later.
REQ-030 When count exceeds DEPTH, the block SHALL issue DEPTH instructions, with no wrap beyond them.

Reset
REQ-031 Reset SHALL asynchronously force the FSM to IDLE, even mid-program, aborting any issue in progress.
REQ-032 On reset, instrWord, newInstr, busy, done and pc SHALL all be 0.
REQ-033 Reset SHALL NOT clear the buffer contents, which are retained across reset.
REQ-034 After Reset deasserts, no newInstr SHALL be issued until a new start is received.

Structure
REQ-035 A shared package SHALL hold DEPTH, GAP, the FSM state enum and the 32-bit instruction word type.
REQ-036 The buffer SHALL be a sub-module instr_buf: a DEPTH x 32 array with one write port and one asynchronous read port.
REQ-037 The GAP counter and the remaining-instruction counter SHALL reside in instr_issuer.

Verification
REQ-038 Scenario: buffer[0]=32'h8C010000, start with count=1 -> one newInstr with instrWord=32'h8C010000; done pulse 6 cycles later; busy then low.
REQ-039 Scenario: buffer[0..2] loaded, start with count=3 -> 3 pulses spaced 6 cycles apart, pc=0,1,2, and instrWord matching the buffer each time.
REQ-040 Scenario: start with count=0 -> done pulse only, no newInstr, and busy never high.
REQ-041 Scenario: start with count=20 and DEPTH=16 -> exactly 16 pulses, with pc ending at 15.
REQ-042 Scenario: Reset after the 2nd pulse of a count=3 program -> all outputs 0 at once and no further pulses; a later start reissues from pc=0.
REQ-043 Scenario: loadEn and start asserted while busy -> buffer unchanged and the program completes with its original count.

Source files
------------

// File: rtl/instr_issuer_pkg.sv
// Shared definitions for the instruction issuer: default sizing, FSM states
// and the instruction word type.
package instr_issuer_pkg;

   localparam int DEPTH = 16;
   localparam int GAP   = 6;

   typedef logic [31:0] instr_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_e;

endpackage

// File: rtl/instr_issuer_if.sv
// Host-side bus of the instruction issuer: buffer load port, program request
// and the instruction stream presented to the CPU.
interface instr_issuer_if #(
   parameter int DEPTH = instr_issuer_pkg::DEPTH
);
   import instr_issuer_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic          loadEn;
   logic [AW-1:0] loadAddr;
   instr_t        loadData;
   logic          start;
   logic [AW:0]   count;
   instr_t        instrWord;
   logic          newInstr;
   logic          busy;
   logic          done;
   logic [AW-1:0] pc;

   modport master (
      output loadEn, loadAddr, loadData, start, count,
      input  instrWord, newInstr, busy, done, pc
   );

   modport slave (
      input  loadEn, loadAddr, loadData, start, count,
      output instrWord, newInstr, busy, done, pc
   );

endinterface

// File: rtl/instr_issuer_buf.sv
// Instruction buffer: DEPTH x 32 array, one synchronous write port and one
// asynchronous read port.
module instr_buf #(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         we_i,
   input  logic [$clog2(DEPTH)-1:0]     waddr_i,
   input  instr_issuer_pkg::instr_t     wdata_i,
   input  logic [$clog2(DEPTH)-1:0]     raddr_i,
   output instr_issuer_pkg::instr_t     rdata_o
);
   import instr_issuer_pkg::*;

   instr_t mem_q [DEPTH];

   // NOTE: storage has no reset on purpose; contents survive a block reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_issuer.sv
// Issues a loaded program to the CPU one instruction every GAP cycles,
// flagging each with a newInstr pulse and finishing with a done pulse.
module instr_issuer #(
   parameter int DEPTH = instr_issuer_pkg::DEPTH,
   parameter int GAP   = instr_issuer_pkg::GAP
) (
   input  logic          Clk,
   input  logic          Reset,
   instr_issuer_if.slave bus
);
   import instr_issuer_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP);

   localparam logic [AW:0]   MAX_CNT    = (AW+1)'(DEPTH);
   // The first pulse lands two edges after start, later ones GAP edges apart.
   localparam logic [GW-1:0] GAP_FIRST  = GW'(1);
   localparam logic [GW-1:0] GAP_RELOAD = GW'(GAP - 2);

   state_e        state_q;
   logic [AW:0]   remain_q;
   logic [GW-1:0] gap_q;
   logic          first_q;
   logic [AW-1:0] pc_q;
   logic [AW-1:0] pc_d;
   instr_t        instr_q;
   logic          new_q;
   logic          busy_q;
   logic          done_q;
   instr_t        rd_data;
   logic          wr_en;

   assign wr_en = bus.loadEn && (state_q == IDLE);
   assign pc_d  = first_q ? pc_q : pc_q + AW'(1);

   instr_buf #(
      .DEPTH (DEPTH)
   ) u_buf (
      .clk     (Clk),
      .we_i    (wr_en),
      .waddr_i (bus.loadAddr),
      .wdata_i (bus.loadData),
      .raddr_i (pc_d),
      .rdata_o (rd_data)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         remain_q <= '0;
         gap_q    <= '0;
         first_q  <= 1'b0;
         pc_q     <= '0;
         instr_q  <= '0;
         new_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking defaults here are overridden later in the same block, making one-cycle pulses.
         new_q  <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.count == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     remain_q <= (bus.count > MAX_CNT) ? MAX_CNT : bus.count;
                     pc_q     <= '0;
                     first_q  <= 1'b1;
                     gap_q    <= GAP_FIRST;
                     busy_q   <= 1'b1;
                     state_q  <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (gap_q != '0) begin
                  gap_q <= gap_q - 1'b1;
               end else if (remain_q != '0) begin
                  state_q  <= ISSUE;
                  new_q    <= 1'b1;
                  instr_q  <= rd_data;
                  pc_q     <= pc_d;
                  remain_q <= remain_q - 1'b1;
                  first_q  <= 1'b0;
               end else begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
               gap_q   <= GAP_RELOAD;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.instrWord = instr_q;
   assign bus.newInstr  = new_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pc        = pc_q;

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a scoreboard queue of expected issues is
// filled when a program starts and drained by a negedge monitor.
module tb_instr_issuer;
   import instr_issuer_pkg::*;

   localparam int T_DEPTH = 16;
   localparam int T_GAP   = 6;
   localparam int AW      = $clog2(T_DEPTH);

   typedef struct {
      logic [AW-1:0] pc;
      instr_t        word;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;

   instr_issuer_if #(.DEPTH(T_DEPTH)) bus ();

   instr_issuer #(
      .DEPTH (T_DEPTH),
      .GAP   (T_GAP)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   int     cyc = 0;
   int     n_tests = 0;
   int     n_fail = 0;
   int     next_new_cyc;
   int     exp_done_cyc;
   bit     done_seen;
   bit     busy_seen;
   instr_t last_word;
   instr_t model_mem [T_DEPTH];
   exp_t   exp_q [$];
   exp_t   mon_e;

   always @(posedge Clk) cyc++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: pops one expectation per newInstr and times every pulse.
   always @(negedge Clk) begin
      if (Reset) begin
         last_word = '0;
      end else begin
         if (bus.busy) busy_seen = 1'b1;
         if (bus.newInstr) begin
            check("newInstr timing", cyc, next_new_cyc);
            check("pulse expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("instrWord", bus.instrWord, mon_e.word);
               check("pc", bus.pc, mon_e.pc);
               check("busy during issue", bus.busy, 1);
               next_new_cyc = cyc + T_GAP;
               if (exp_q.size() == 0) exp_done_cyc = cyc + T_GAP;
            end
         end else begin
            check("instrWord hold", bus.instrWord, last_word);
         end
         last_word = bus.instrWord;
         if (bus.done) begin
            done_seen = 1'b1;
            check("done timing", cyc, exp_done_cyc);
            check("busy at done", bus.busy, 0);
         end
      end
   end

   task automatic load(input int addr, input instr_t data);
      bus.loadEn   = 1'b1;
      bus.loadAddr = AW'(addr);
      bus.loadData = data;
      model_mem[addr] = data;
      @(negedge Clk);
      bus.loadEn = 1'b0;
   endtask

   task automatic start_prog(input int cnt);
      int   n;
      exp_t e;
      n = (cnt > T_DEPTH) ? T_DEPTH : cnt;
      for (int i = 0; i < n; i++) begin
         e.pc   = AW'(i);
         e.word = model_mem[i];
         exp_q.push_back(e);
      end
      done_seen    = 1'b0;
      busy_seen    = 1'b0;
      next_new_cyc = cyc + 3;
      exp_done_cyc = cyc + 1;
      bus.count    = (AW+1)'(cnt);
      bus.start    = 1'b1;
      @(negedge Clk);
      bus.start = 1'b0;
   endtask

   task automatic run_prog(input int cnt, input bit intrude);
      int n;
      n = (cnt > T_DEPTH) ? T_DEPTH : cnt;
      start_prog(cnt);
      if (intrude) begin
         repeat (3) @(negedge Clk);
         bus.loadEn   = 1'b1;
         bus.loadAddr = '0;
         bus.loadData = 32'hDEADBEEF;
         bus.start    = 1'b1;
         bus.count    = (AW+1)'(1);
         @(negedge Clk);
         bus.loadEn = 1'b0;
         bus.start  = 1'b0;
      end
      for (int k = 0; k < (n + 2) * T_GAP + 4 && !done_seen; k++) begin
         @(negedge Clk);
         #1;
      end
      check("done seen", done_seen, 1);
      check("scoreboard drained", exp_q.size(), 0);
      if (n == 0) check("busy never high", busy_seen, 0);
      else        check("pc final", bus.pc, n - 1);
      @(negedge Clk);
      #1;
      check("done one cycle", bus.done, 0);
      check("busy after done", bus.busy, 0);
      exp_q.delete();
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " instrWord"}, bus.instrWord, 0);
      check({tag, " newInstr"}, bus.newInstr, 0);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " done"}, bus.done, 0);
      check({tag, " pc"}, bus.pc, 0);
   endtask

   initial begin
      Reset        = 1'b1;
      bus.loadEn   = 1'b0;
      bus.loadAddr = '0;
      bus.loadData = '0;
      bus.start    = 1'b0;
      bus.count    = '0;
      repeat (2) @(negedge Clk);
      #1;
      check_outputs_zero("reset");
      Reset = 1'b0;
      @(negedge Clk);

      // Single instruction
      load(0, 32'h8C010000);
      run_prog(1, 1'b0);

      // Three instructions
      load(1, 32'h20420001);
      load(2, 32'hAC030004);
      run_prog(3, 1'b0);

      // Empty program
      run_prog(0, 1'b0);

      // Oversized count saturates at DEPTH
      for (int i = 0; i < T_DEPTH; i++) load(i, 32'h10000000 | (i << 8) | i);
      run_prog(20, 1'b0);

      // Reset after the second pulse aborts the program
      start_prog(3);
      for (int k = 0; k < 4 * T_GAP && exp_q.size() > 1; k++) begin
         @(negedge Clk);
         #1;
      end
      check("two pulses before reset", exp_q.size(), 1);
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      check_outputs_zero("abort");
      exp_q.delete();
      @(negedge Clk);
      #3;
      Reset = 1'b0;
      repeat (4 * T_GAP) @(negedge Clk);
      run_prog(3, 1'b0);

      // loadEn and start while busy are ignored
      run_prog(2, 1'b1);
      run_prog(1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
